// File: rtl/idct4_sched.sv
// idct4_sched: scheduler/sequencer for the 4-tap systolic IDCT column datapath (optional IDCT_SCHED_PERF_EN adds stall/block counters)
module idct4_sched #(
  parameter int DW = 16,
  parameter int VW = 4*DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [VW-1:0] in_vec,
  output logic [DW-1:0] tap1,
  output logic [DW-1:0] tap2,
  output logic [DW-1:0] tap3,
  output logic [DW-1:0] tap4,
  output logic [2:0]    csel1,
  output logic [2:0]    csel2,
  output logic [2:0]    csel3,
  output logic [2:0]    csel4,
  output logic          dp_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_idx,
  output logic          out_last
`ifdef IDCT_SCHED_PERF_EN
  ,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   blk_cnt
`endif
);
  localparam logic IDLE  = 1'b0;
  localparam logic ISSUE = 1'b1;
  localparam logic [2:0] CZERO = 3'b011;
  logic          state;
  logic [1:0]    k;
  logic [VW-1:0] cur;
  logic          v1, v2, v3, v4;
  logic [1:0]    idx1, idx2, idx3, idx4;
  logic [3*DW-1:0] vec1;
  logic [2*DW-1:0] vec2;
  logic [DW-1:0]   vec3;
  logic          issuing;
  // Coefficient select for lane j, pass k: [2] negate, [1:0] 00=64 01=36 10=83 11=0
  function automatic logic [2:0] coef(input logic [1:0] j, input logic [1:0] kk);
    logic [11:0] row;
    row = j == 2'd1 ? 12'b110_101_001_010 :
          j == 2'd2 ? 12'b000_100_100_000 :
          j == 2'd3 ? 12'b101_010_110_001 : 12'b000_000_000_000;
    return row[3*kk +: 3];
  endfunction
  assign issuing   = state == ISSUE;
  assign dp_en     = !(out_valid && !out_ready);
  assign in_ready  = dp_en && (state == IDLE || k == 2'd3);
  assign out_valid = v4;
  assign out_idx   = idx4;
  assign out_last  = v4 && idx4 == 2'd3;
  // Pass sequencer: capture vector on accept, step k each enabled cycle, reload with no bubble after k=3
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      k     <= '0;
      cur   <= '0;
    end else if (dp_en) begin
      if (in_valid && in_ready) begin
        cur   <= in_vec;
        k     <= '0;
        state <= ISSUE;
      end else if (issuing) begin
        k     <= k + 2'd1;
        state <= k == 2'd3 ? IDLE : ISSUE;
      end
    end
  end
  // Lane 1 launches pass k; lanes 2..4 shift the pass one stage per enabled cycle to skew the taps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {v1, v2, v3, v4}         <= '0;
      {idx1, idx2, idx3, idx4} <= '0;
      {vec1, vec2, vec3}       <= '0;
      {tap1, tap2, tap3, tap4} <= '0;
      {csel1, csel2, csel3, csel4} <= '0;
    end else if (dp_en) begin
      v1    <= issuing;
      idx1  <= issuing ? k : 2'd0;
      vec1  <= cur[VW-1:DW];
      tap1  <= issuing ? cur[DW-1:0] : '0;
      csel1 <= issuing ? coef(2'd0, k) : CZERO;
      v2    <= v1;
      idx2  <= idx1;
      vec2  <= vec1[3*DW-1:DW];
      tap2  <= v1 ? vec1[DW-1:0] : '0;
      csel2 <= v1 ? coef(2'd1, idx1) : CZERO;
      v3    <= v2;
      idx3  <= idx2;
      vec3  <= vec2[2*DW-1:DW];
      tap3  <= v2 ? vec2[DW-1:0] : '0;
      csel3 <= v2 ? coef(2'd2, idx2) : CZERO;
      v4    <= v3;
      idx4  <= idx3;
      tap4  <= v3 ? vec3 : '0;
      csel4 <= v3 ? coef(2'd3, idx3) : CZERO;
    end
  end
`ifdef IDCT_SCHED_PERF_EN
  // Saturating counters: stalled cycles and completed (accepted last) blocks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      blk_cnt   <= '0;
    end else begin
      if (!dp_en && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (out_last && out_ready && blk_cnt != 16'hFFFF) blk_cnt <= blk_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_idct4_sched.sv
// tb_idct4_sched: directed bench for idct4_sched with a behavioural model of the systolic datapath
module tb_idct4_sched;
  localparam int DW = 16;
  localparam int VW = 4*DW;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [VW-1:0] in_vec = '0;
  logic in_ready, dp_en, out_valid, out_last;
  logic [DW-1:0] tap1, tap2, tap3, tap4;
  logic [2:0] csel1, csel2, csel3, csel4;
  logic [1:0] out_idx;
`ifdef IDCT_SCHED_PERF_EN
  logic [15:0] stall_cnt, blk_cnt;
`endif
  int checks = 0;
  int errors = 0;
  logic signed [23:0] ps1, ps2, ps3, res;
  logic signed [23:0] ra [4] = '{24'sd566, -24'sd388, 24'sd132, -24'sd54};
  logic signed [23:0] rb [4] = '{24'sd83, 24'sd36, -24'sd36, -24'sd83};
  logic [VW-1:0] vec_a = {16'd4, 16'd3, 16'd2, 16'd1};
  logic [VW-1:0] vec_b = {16'd0, 16'd0, 16'd1, 16'd0};

  idct4_sched #(.DW(DW), .VW(VW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .tap1(tap1), .tap2(tap2), .tap3(tap3), .tap4(tap4),
    .csel1(csel1), .csel2(csel2), .csel3(csel3), .csel4(csel4),
    .dp_en(dp_en), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_last(out_last)
`ifdef IDCT_SCHED_PERF_EN
    , .stall_cnt(stall_cnt), .blk_cnt(blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic signed [23:0] cval(input logic [2:0] c);
    logic signed [23:0] m;
    m = c[1:0] == 2'd0 ? 24'sd64 : c[1:0] == 2'd1 ? 24'sd36 : c[1:0] == 2'd2 ? 24'sd83 : 24'sd0;
    return c[2] ? -m : m;
  endfunction

  // Datapath model: registered partial sums advance with dp_en, final add is combinational
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps1 <= '0;
      ps2 <= '0;
      ps3 <= '0;
    end else if (dp_en) begin
      ps1 <= 24'($signed(tap1)) * cval(csel1);
      ps2 <= ps1 + 24'($signed(tap2)) * cval(csel2);
      ps3 <= ps2 + 24'($signed(tap3)) * cval(csel3);
    end
  end
  assign res = ps3 + 24'($signed(tap4)) * cval(csel4);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [1:0] idx, input logic signed [23:0] r, input logic last);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_idx"}, 32'(out_idx), 32'(idx));
    chk({tag, "_res"}, {8'h0, res}, {8'h0, r});
    chk({tag, "_last"}, 32'(out_last), 32'(last));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_tap1", 32'(tap1), 32'd0);
    chk("rst_tap4", 32'(tap4), 32'd0);
    chk("rst_csel1", 32'(csel1), 32'd0);
    chk("rst_csel4", 32'(csel4), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    reset = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_dp_en", 32'(dp_en), 32'd1);
    // single vector, latency and in_ready shape
    in_vec = vec_a;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("sv_rdy_e0", 32'(in_ready), 32'd0);
    step();
    chk("sv_rdy_e1", 32'(in_ready), 32'd0);
    chk("sv_tap1", 32'(tap1), 32'd1);
    chk("sv_csel1", 32'(csel1), 32'd0);
    step();
    chk("sv_rdy_e2", 32'(in_ready), 32'd0);
    chk("sv_tap2", 32'(tap2), 32'd2);
    chk("sv_csel2", 32'(csel2), 32'b010);
    chk("sv_valid_e2", 32'(out_valid), 32'd0);
    step();
    chk("sv_rdy_e3", 32'(in_ready), 32'd1);
    chk("sv_tap3", 32'(tap3), 32'd3);
    chk("sv_csel3", 32'(csel3), 32'b000);
    chk("sv_valid_e3", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_res("sv", 2'(i), ra[i], i == 3);
    end
    step();
    chk("sv_done", 32'(out_valid), 32'd0);
    // lane skew
    in_vec = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_vec = '0;
    step();
    chk("sk_tap1", 32'(tap1), 32'h1111);
    chk("sk_tap2_e1", 32'(tap2), 32'h0);
    step();
    chk("sk_tap2", 32'(tap2), 32'h2222);
    chk("sk_csel2", 32'(csel2), 32'b010);
    chk("sk_tap3_e2", 32'(tap3), 32'h0);
    step();
    chk("sk_tap3", 32'(tap3), 32'h3333);
    chk("sk_csel3", 32'(csel3), 32'b000);
    chk("sk_tap4_e3", 32'(tap4), 32'h0);
    step();
    chk("sk_tap4", 32'(tap4), 32'h4444);
    chk("sk_csel4", 32'(csel4), 32'b001);
    chk_res("sk", 2'd0, ra[0] * 24'sd4369, 1'b0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_res("sk", 2'(i), ra[i] * 24'sd4369, i == 3);
    end
    step();
    chk("sk_done", 32'(out_valid), 32'd0);
    // back-to-back vectors; in_vec changes while not accepted
    in_vec = vec_a;
    in_valid = 1'b1;
    step();
    in_vec = vec_b;
    chk("bb_rdy_e0", 32'(in_ready), 32'd0);
    step();
    chk("bb_rdy_e1", 32'(in_ready), 32'd0);
    step();
    chk("bb_rdy_e2", 32'(in_ready), 32'd0);
    step();
    chk("bb_rdy_e3", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bb_rdy_e4", 32'(in_ready), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk_res("bb", 2'(i % 4), i < 4 ? ra[i] : rb[i-4], i % 4 == 3);
      step();
    end
    chk("bb_done", 32'(out_valid), 32'd0);
    // backpressure on idx 1
    in_vec = vec_a;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk_res("bp0", 2'd0, ra[0], 1'b0);
    step();
    chk_res("bp1", 2'd1, ra[1], 1'b0);
    out_ready = 1'b0;
    #1;
    chk("bp_dp_en", 32'(dp_en), 32'd0);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_res("bp_hold", 2'd1, ra[1], 1'b0);
      chk("bp_hold_en", 32'(dp_en), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_en", 32'(dp_en), 32'd1);
    chk_res("bp_rel", 2'd1, ra[1], 1'b0);
    step();
    chk_res("bp2", 2'd2, ra[2], 1'b0);
    step();
    chk_res("bp3", 2'd3, ra[3], 1'b1);
    step();
    chk("bp_done", 32'(out_valid), 32'd0);
    // reset mid-operation
    in_vec = vec_a;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_tap1", 32'(tap1), 32'd0);
    chk("mr_tap2", 32'(tap2), 32'd0);
    chk("mr_csel1", 32'(csel1), 32'd0);
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("mr_no_valid", 32'(out_valid), 32'd0);
    end
    // stall plus two back-to-back vectors
    in_vec = vec_a;
    in_valid = 1'b1;
    step();
    in_vec = vec_b;
    for (int i = 0; i < 4; i++) step();
    in_valid = 1'b0;
    chk_res("pf0", 2'd0, ra[0], 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_res("pf_hold", 2'd0, ra[0], 1'b0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk_res("pf", 2'(i % 4), i < 4 ? ra[i] : rb[i-4], i % 4 == 3);
      step();
    end
    chk("pf_done", 32'(out_valid), 32'd0);
`ifdef IDCT_SCHED_PERF_EN
    chk("pf_stall_cnt", 32'(stall_cnt), 32'd5);
    chk("pf_blk_cnt", 32'(blk_cnt), 32'd2);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
